// File: rtl/game_tick_scheduler.sv
// Game-rate strobe generator (60 Hz frame tick, two-phase 20 Hz tick, debounce enable)
// plus the IDLE/RUN/OVER game FSM and speed level. Optional PAUSE state: define GAME_TICK_PAUSE_EN.
module game_tick_scheduler #(
    parameter int V_TRIG       = 480,
    parameter int DIV20        = 3,
    parameter int OVER_FRAMES  = 120,
    parameter int SPEED_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic       i_start_pulse,
    input  logic       i_crash,
    input  logic       i_pause,
    output logic       o_tick_60hz,
    output logic [1:0] o_tick_20hz,
    output logic       o_debounce_en,
    output logic       o_obs_tick,
    output logic [1:0] o_state,
    output logic [2:0] o_speed,
    output logic       o_game_over_pulse
);
    localparam int DIV_W  = (DIV20 > 1) ? $clog2(DIV20) : 1;
    localparam int OVER_W = $clog2(OVER_FRAMES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV20 - 1);
    localparam logic [OVER_W-1:0] OVER_LAST  = OVER_W'(OVER_FRAMES - 1);
    localparam logic [9:0]        SPEED_LAST = 10'(SPEED_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_OVER  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    state_t              state_reg;
    logic                tick_60_reg;
    logic [1:0]          tick_20_reg;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic                vpos5_reg;
    logic                debounce_reg;
    logic                game_over_reg;
    logic [OVER_W-1:0]   over_cnt_reg;
    logic [9:0]          speed_cnt_reg;
    logic [2:0]          speed_reg;
    logic                frame_hit;

    assign frame_hit = (i_vpos == 10'(V_TRIG)) && (i_hpos == 10'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            tick_60_reg   <= 1'b0;
            tick_20_reg   <= 2'b00;
            div_cnt_reg   <= '0;
            vpos5_reg     <= 1'b0;
            debounce_reg  <= 1'b0;
            game_over_reg <= 1'b0;
            over_cnt_reg  <= '0;
            speed_cnt_reg <= '0;
            speed_reg     <= '0;
        end else begin
            tick_60_reg <= frame_hit;

            // Phase 1 trails phase 0 by one cycle; a reset in between kills phase 1.
            tick_20_reg[1] <= tick_20_reg[0];
            tick_20_reg[0] <= 1'b0;
            if (tick_60_reg) begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_reg    <= '0;
                    tick_20_reg[0] <= 1'b1;
                end else begin
                    div_cnt_reg <= div_cnt_reg + 1'b1;
                end
            end

            vpos5_reg     <= i_vpos[5];
            debounce_reg  <= i_vpos[5] & ~vpos5_reg;
            game_over_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (i_start_pulse) begin
                        state_reg     <= ST_RUN;
                        speed_reg     <= '0;
                        speed_cnt_reg <= '0;
                    end
                end
                ST_RUN: begin
                    if (i_crash) begin
                        state_reg     <= ST_OVER;
                        game_over_reg <= 1'b1;
                        over_cnt_reg  <= '0;
                    end
`ifdef GAME_TICK_PAUSE_EN
                    else if (i_pause) begin
                        state_reg <= ST_PAUSE;
                    end
`endif
                    else if (tick_60_reg) begin
                        if (speed_cnt_reg == SPEED_LAST) begin
                            speed_cnt_reg <= '0;
                            if (speed_reg != 3'd7) begin
                                speed_reg <= speed_reg + 3'd1;
                            end
                        end else begin
                            speed_cnt_reg <= speed_cnt_reg + 10'd1;
                        end
                    end
                end
                ST_OVER: begin
                    if (i_start_pulse) begin
                        state_reg     <= ST_RUN;
                        speed_reg     <= '0;
                        speed_cnt_reg <= '0;
                    end else if (tick_60_reg) begin
                        if (over_cnt_reg == OVER_LAST) begin
                            state_reg    <= ST_IDLE;
                            over_cnt_reg <= '0;
                        end else begin
                            over_cnt_reg <= over_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
`ifdef GAME_TICK_PAUSE_EN
                    // Resume keeps the current speed and speed counter.
                    if (i_pause || i_start_pulse) begin
                        state_reg <= ST_RUN;
                    end
`else
                    state_reg <= ST_IDLE;
`endif
                end
            endcase
        end
    end

    assign o_tick_60hz       = tick_60_reg;
    assign o_tick_20hz       = tick_20_reg;
    assign o_debounce_en     = debounce_reg;
    assign o_obs_tick        = tick_60_reg && (state_reg == ST_RUN);
    assign o_state           = state_reg;
    assign o_speed           = speed_reg;
    assign o_game_over_pulse = game_over_reg;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// Randomized bench for game_tick_scheduler against a frame/event-count reference model.
module tb_game_tick_scheduler;
    localparam int V_TRIG       = 480;
    localparam int DIV20        = 3;
    localparam int OVER_FRAMES  = 120;
    localparam int SPEED_FRAMES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hpos = 10'd1;
    logic [9:0] vpos = 10'd0;
    logic       start = 1'b0;
    logic       crash = 1'b0;
    logic       pause = 1'b0;
    logic       o_tick_60hz;
    logic [1:0] o_tick_20hz;
    logic       o_debounce_en;
    logic       o_obs_tick;
    logic [1:0] o_state;
    logic [2:0] o_speed;
    logic       o_game_over_pulse;

    game_tick_scheduler #(
        .V_TRIG(V_TRIG), .DIV20(DIV20), .OVER_FRAMES(OVER_FRAMES), .SPEED_FRAMES(SPEED_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .i_hpos(hpos), .i_vpos(vpos),
        .i_start_pulse(start), .i_crash(crash), .i_pause(pause),
        .o_tick_60hz(o_tick_60hz), .o_tick_20hz(o_tick_20hz), .o_debounce_en(o_debounce_en),
        .o_obs_tick(o_obs_tick), .o_state(o_state), .o_speed(o_speed),
        .o_game_over_pulse(o_game_over_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counts of events since reset rather than counter registers.
    int   m_frames, m_state, m_run, m_over;
    logic m_v5, m_tick60, m_deb, m_gop;
    logic [1:0] m_t20;
    int   obs_cnt, t20a_cnt, t20b_cnt, deb_cnt, gop_cnt;

    function automatic int exp_speed();
        int s;
        s = m_run / SPEED_FRAMES;
        return (s > 7) ? 7 : s;
    endfunction

    task automatic step();
        logic cur_tick;
        if (rst) begin
            m_frames = 0; m_state = 0; m_run = 0; m_over = 0;
            m_v5 = 1'b0; m_tick60 = 1'b0; m_deb = 1'b0; m_gop = 1'b0; m_t20 = 2'b00;
        end else begin
            cur_tick = m_tick60;
            m_t20[1] = m_t20[0];
            m_t20[0] = 1'b0;
            if (cur_tick) begin
                m_frames++;
                if (m_frames % DIV20 == 0) m_t20[0] = 1'b1;
            end
            m_tick60 = (vpos == 10'(V_TRIG)) && (hpos == 10'd0);
            m_deb = vpos[5] && !m_v5;
            m_v5  = vpos[5];
            m_gop = 1'b0;
            case (m_state)
                0: if (start) begin m_state = 1; m_run = 0; end
                1: begin
                    if (crash) begin m_state = 2; m_gop = 1'b1; m_over = 0; end
`ifdef GAME_TICK_PAUSE_EN
                    else if (pause) m_state = 3;
`endif
                    else if (cur_tick) m_run++;
                end
                2: begin
                    if (start) begin m_state = 1; m_run = 0; end
                    else if (cur_tick) begin
                        m_over++;
                        if (m_over == OVER_FRAMES) m_state = 0;
                    end
                end
                default: if (pause || start) m_state = 1;
            endcase
        end
        @(posedge clk);
        #1;
        check("tick60", 16'(o_tick_60hz), 16'(m_tick60));
        check("tick20", 16'(o_tick_20hz), 16'(m_t20));
        check("debounce", 16'(o_debounce_en), 16'(m_deb));
        check("obs_tick", 16'(o_obs_tick), 16'(m_tick60 && (m_state == 1)));
        check("state", 16'(o_state), 16'(m_state));
        check("speed", 16'(o_speed), 16'(exp_speed()));
        check("game_over", 16'(o_game_over_pulse), 16'(m_gop));
        if (o_obs_tick)        obs_cnt++;
        if (o_tick_20hz[0])    t20a_cnt++;
        if (o_tick_20hz[1])    t20b_cnt++;
        if (o_debounce_en)     deb_cnt++;
        if (o_game_over_pulse) gop_cnt++;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic rand_pos();
        hpos = 10'($urandom_range(1, 799));
        vpos = 10'($urandom_range(0, 524));
    endtask

    task automatic frame(input int gap);
        repeat (gap) begin rand_pos(); step(); end
        hpos = 10'd0;
        vpos = 10'(V_TRIG);
        step();
        rand_pos();
    endtask

    task automatic phase_done(input string name);
        $display("[TB] phase %s done: tests=%0d failed=%0d", name, n_tests, n_fail);
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        rand_pos();
        repeat (2) step();
        rst = 1'b0;
        phase_done("reset");

        t20a_cnt = 0; t20b_cnt = 0;
        for (int f = 0; f < 6; f++) frame(3 + f);
        step(); step();
        check("t20_phase0_count", 16'(t20a_cnt), 16'd2);
        check("t20_phase1_count", 16'(t20b_cnt), 16'd2);
        phase_done("raster_6_frames");

        hpos = 10'd5; vpos = 10'd0; step();
        deb_cnt = 0;
        for (int v = 0; v < 64; v++) begin vpos = 10'(v); step(); end
        step();
        check("debounce_count", 16'(deb_cnt), 16'd1);
        phase_done("vpos_sweep");

        start = 1'b1; rand_pos(); step();
        check("start_to_run", 16'(o_state), 16'd1);
        obs_cnt = 0; gop_cnt = 0;
        for (int f = 0; f < 3; f++) frame(3);
        step();
        check("obs_3_frames", 16'(obs_cnt), 16'd3);
        crash = 1'b1; step(); crash = 1'b0;
        check("crash_to_over", 16'(o_state), 16'd2);
        obs_cnt = 0;
        repeat (119) frame(2);
        step();
        check("over_before_expiry", 16'(o_state), 16'd2);
        frame(2);
        step();
        check("over_to_idle", 16'(o_state), 16'd0);
        check("obs_in_over", 16'(obs_cnt), 16'd0);
        check("game_over_once", 16'(gop_cnt), 16'd1);
        phase_done("run_crash_over");

        start = 1'b1; step();
        for (int f = 0; f < 5; f++) frame(2);
        step();
        check("speed_after_5", 16'(o_speed), 16'd2);
        for (int f = 0; f < 15; f++) frame(2);
        step();
        check("speed_saturated", 16'(o_speed), 16'd7);
        crash = 1'b1; step(); crash = 1'b0;
        frame(2); step();
        check("speed_hold_over", 16'(o_speed), 16'd7);
        start = 1'b1; step();
        check("speed_cleared", 16'(o_speed), 16'd0);
        phase_done("speed");

        start = 1'b1; crash = 1'b1; step(); crash = 1'b0;
        check("crash_priority", 16'(o_state), 16'd2);
        start = 1'b1; step();
        for (int f = 0; f < 4; f++) frame(2);
        step();
        pause = 1'b1; step();
`ifdef GAME_TICK_PAUSE_EN
        check("pause_enter", 16'(o_state), 16'd3);
        obs_cnt = 0;
        crash = 1'b1;
        for (int f = 0; f < 5; f++) frame(2);
        step();
        crash = 1'b0;
        check("pause_crash_ignored", 16'(o_state), 16'd3);
        check("pause_no_obs", 16'(obs_cnt), 16'd0);
        check("pause_speed_frozen", 16'(o_speed), 16'd2);
        pause = 1'b1; step();
        check("pause_exit", 16'(o_state), 16'd1);
`else
        check("pause_ignored", 16'(o_state), 16'd1);
`endif
        phase_done("pause");

        waited = 0;
        while (o_tick_20hz[0] !== 1'b1 && waited < 200) begin
            if (waited % 4 == 3) begin hpos = 10'd0; vpos = 10'(V_TRIG); end
            else rand_pos();
            step();
            waited++;
        end
        if (waited >= 200) check("t20_wait_timeout", 16'd0, 16'd1);
        rst = 1'b1; rand_pos(); step(); rst = 1'b0;
        check("rst_abort_t20", 16'(o_tick_20hz), 16'd0);
        check("rst_state", 16'(o_state), 16'd0);
        check("rst_speed", 16'(o_speed), 16'd0);
        phase_done("reset_abort");

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0) begin hpos = 10'd0; vpos = 10'(V_TRIG); end
            else rand_pos();
            start = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 24) == 0) crash = ~crash;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0; crash = 1'b0;
        phase_done("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Generates all game-rate timing strobes from the VGA raster position and sequences the run state of the game. It produces the 60 Hz frame tick, the two-phase 20 Hz pipelined tick, the debounce enable and a gated obstacle tick. It also holds the IDLE/RUN/OVER game state machine and a difficulty (speed) level. It sits in the top level between graphics_top (hpos/vpos) and player_controller/obstacles.

Parameters:
V_TRIG, 480, vpos line on which the frame tick fires (first vblank line)
DIV20, 3, frame ticks per 20 Hz tick (≥2)
OVER_FRAMES, 120, frames spent in OVER before auto-return to IDLE (≥1)
SPEED_FRAMES, 600, RUN frames per speed increment (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
i_hpos  in  10  current VGA horizontal position
i_vpos  in  10  current VGA vertical position
i_start_pulse  in  1  one-cycle game start request
i_crash  in  1  collision flag, level
i_pause  in  1  one-cycle pause toggle request (used only with PAUSE_EN)
o_tick_60hz  out  1  one-cycle pulse per frame
o_tick_20hz  out  2  [0] pulse, then [1] pulse the following cycle
o_debounce_en  out  1  one-cycle pulse on rising edge of i_vpos[5]
o_obs_tick  out  1  o_tick_60hz gated by RUN state
o_state  out  2  00 IDLE, 01 RUN, 10 OVER, 11 PAUSE
o_speed  out  3  difficulty level 0..7
o_game_over_pulse  out  1  one-cycle pulse on RUN→OVER

Behaviour:
- Reset: every output 0, state IDLE, all counters 0, vpos[5] history register 0.
- Frame detect: a combinational hit is i_vpos==V_TRIG && i_hpos==0. o_tick_60hz is registered and high in the cycle after the hit. Exactly one pulse per frame.
- 20 Hz: a frame counter counts 0..DIV20-1, advancing on each o_tick_60hz.
  - In the cycle after a tick where the counter is DIV20-1, o_tick_20hz[0]=1 and the counter wraps to 0.
  - o_tick_20hz[1]=1 in the next cycle. The two bits are never high together.
  - The divider free-runs in every state.
- Debounce: register i_vpos[5]. o_debounce_en=1 for one cycle, in the cycle after the register sees 0→1.
- FSM, evaluated every clk:
  - IDLE: i_start_pulse → RUN. Clear o_speed and the speed counter.
  - RUN: i_crash=1 → OVER, with o_game_over_pulse=1 for one cycle and the over counter cleared. i_crash has priority over i_start_pulse and i_pause in the same cycle.
  - OVER: the over counter increments on each o_tick_60hz. On reaching OVER_FRAMES → IDLE. i_start_pulse → RUN immediately (speed cleared). i_crash is ignored.
- o_obs_tick = registered o_tick_60hz && state==RUN, so it is coincident with o_tick_60hz.
- Speed: in RUN, a 10-bit counter increments on each o_tick_60hz.
  - On reaching SPEED_FRAMES-1 it wraps to 0 and o_speed increments.
  - o_speed saturates at 7 and never wraps.
  - o_speed holds its value in OVER and is cleared on entry to RUN from IDLE or OVER.
- Reset mid-operation: an in-flight 20 Hz pair is aborted. If o_tick_20hz[0] fired, [1] does not follow.

Optional Feature:
GAME_TICK_PAUSE_EN
- Defined:
  - i_pause in RUN → PAUSE (o_state=11). i_pause in PAUSE → RUN.
  - In PAUSE, o_obs_tick=0 and the speed counter is frozen.
  - i_crash is ignored in PAUSE. i_start_pulse in PAUSE → RUN without clearing speed.
- Undefined: i_pause is ignored, PAUSE is unreachable, and o_state never equals 11.

Test Plan:
- Raster sweep, 800x525 counts, 6 frames after reset → 6 o_tick_60hz pulses, each one cycle after (hpos=0, vpos=480). o_tick_20hz[0] on frames 3 and 6, with [1] exactly one cycle later each time.
- vpos sweep 0..63 → one o_debounce_en pulse, in the cycle after vpos goes 31→32.
- i_start_pulse in IDLE, then 3 frames → o_state=01, 3 o_obs_tick pulses. Then i_crash=1 → o_state=10, o_game_over_pulse one cycle, o_obs_tick stays 0. After 120 frames → o_state=00.
- With SPEED_FRAMES=2, RUN for 20 frames → o_speed steps every 2 frames and holds at 7. Then i_start_pulse from OVER → o_speed=0.
- i_crash and i_start_pulse asserted in the same RUN cycle → OVER. Assert rst in the cycle o_tick_20hz[0]=1 → no [1] pulse and all outputs 0 next cycle.
- With GAME_TICK_PAUSE_EN: i_pause in RUN → o_state=11, no o_obs_tick for 5 frames, o_speed frozen. i_crash is ignored. A second i_pause → o_state=01.
